// File: rtl/rv32i_types.sv
// Shared types for the cache physical-memory side.
// Purpose: line/beat geometry constants, the cache line type and the
// state encoding used by the pmem burst responder.
// Ports: none (package).
package rv32i_types;

  localparam int PMEM_LINE_BITS = 256;
  localparam int PMEM_BEAT_BITS = 64;
  localparam int PMEM_BEATS     = PMEM_LINE_BITS / PMEM_BEAT_BITS;

  typedef logic [PMEM_LINE_BITS-1:0] pmem_line_t;

  // Fixed encoding so the state register stays readable in waveforms
  // and matches older netlists that used plain 2-bit constants.
  typedef enum logic [1:0] {
    PMEM_IDLE  = 2'd0,
    PMEM_READ  = 2'd1,
    PMEM_WRITE = 2'd2,
    PMEM_RESP  = 2'd3
  } pmem_rsp_state_t;

endpackage

// File: rtl/pmem_burst_responder_line_beat_buffer.sv
// line_beat_buffer: one cache-line register that can be filled either a
// whole line at a time or one burst beat at a time, and that presents the
// beat selected by beat_idx_i as a slice.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (clears the line)
//   line_load_i   - load the whole line from line_i
//   line_i        - full line input
//   beat_load_i   - store beat_i into slice beat_idx_i
//   beat_idx_i    - beat index for both load and slice output
//   beat_i        - single beat input
//   line_o        - current line contents
//   beat_o        - slice [beat_idx_i*BEAT_BITS +: BEAT_BITS] of the line
module line_beat_buffer
  import rv32i_types::*;
#(
  parameter int LINE_BITS = PMEM_LINE_BITS,
  parameter int BEAT_BITS = PMEM_BEAT_BITS,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_load_i,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic                 beat_load_i,
  input  logic [CNT_W-1:0]     beat_idx_i,
  input  logic [BEAT_BITS-1:0] beat_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic [BEAT_BITS-1:0] beat_o
);

  logic [LINE_BITS-1:0] line_q;

  // A full-line load takes priority; the controller never asks for both
  // in the same cycle, the ordering just keeps the behaviour defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (line_load_i) begin
      line_q <= line_i;
    end else if (beat_load_i) begin
      line_q[beat_idx_i*BEAT_BITS +: BEAT_BITS] <= beat_i;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[beat_idx_i*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: responder end of the cache pmem_read/pmem_write/
// pmem_resp handshake. Each whole-line request is carried out as a fixed
// burst of BEATS beats on the downstream burst interface, then answered
// with a single-cycle pmem_resp.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   pmem_address/read/write     - line request from the cache
//   pmem_wdata                  - line to write
//   pmem_rdata                  - last line read, valid from the pmem_resp cycle
//   pmem_resp                   - one-cycle completion pulse
//   burst_address               - line-aligned address, stable for the burst
//   burst_read / burst_write    - downstream burst direction (never both)
//   burst_wdata                 - current write beat
//   burst_rdata / burst_resp    - downstream read beat and per-beat ack
module pmem_burst_responder
  import rv32i_types::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = PMEM_LINE_BITS,
  parameter int BEAT_BITS = PMEM_BEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic [ADDR_BITS-1:0] burst_address,
  output logic                 burst_read,
  output logic                 burst_write,
  output logic [BEAT_BITS-1:0] burst_wdata,
  input  logic [BEAT_BITS-1:0] burst_rdata,
  input  logic                 burst_resp
);

  localparam int BEATS    = LINE_BITS / BEAT_BITS;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_BITS-1:0] OFF_MASK  = ADDR_BITS'((64'd1 << OFF_BITS) - 64'd1);

  pmem_rsp_state_t      state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 is_read_q, is_read_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;

  logic                 line_load;
  logic                 beat_load;
  logic [LINE_BITS-1:0] buf_line;
  logic [BEAT_BITS-1:0] buf_beat;

  // The same buffer latches the write line and assembles read beats;
  // only one transfer is ever in flight, so the two uses never overlap.
  // Read data is copied to rdata_q only on completion, which keeps
  // pmem_rdata stable while a later read is still assembling.
  line_beat_buffer #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS),
    .CNT_W     (CNT_W)
  ) u_line_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_load_i (line_load),
    .line_i      (pmem_wdata),
    .beat_load_i (beat_load),
    .beat_idx_i  (cnt_q),
    .beat_i      (burst_rdata),
    .line_o      (buf_line),
    .beat_o      (buf_beat)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    rdata_d   = rdata_q;
    line_load = 1'b0;
    beat_load = 1'b0;

    case (state_q)
      PMEM_IDLE: begin
        // Write has priority when both requests are (illegally) high.
        if (pmem_write) begin
          state_d   = PMEM_WRITE;
          cnt_d     = '0;
          addr_d    = pmem_address & ~OFF_MASK;
          is_read_d = 1'b0;
          line_load = 1'b1;
        end else if (pmem_read) begin
          state_d   = PMEM_READ;
          cnt_d     = '0;
          addr_d    = pmem_address & ~OFF_MASK;
          is_read_d = 1'b1;
        end
      end

      PMEM_READ, PMEM_WRITE: begin
        if (burst_resp) begin
          beat_load = (state_q == PMEM_READ);
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = PMEM_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      PMEM_RESP: begin
        state_d = PMEM_IDLE;
        if (is_read_q) begin
          rdata_d = buf_line;
        end
      end

      default: state_d = PMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PMEM_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      rdata_q   <= rdata_d;
    end
  end

  assign burst_address = addr_q;
  assign burst_read    = (state_q == PMEM_READ);
  assign burst_write   = (state_q == PMEM_WRITE);
  assign burst_wdata   = (state_q == PMEM_WRITE) ? buf_beat : '0;
  assign pmem_resp     = (state_q == PMEM_RESP);
  // In the completion cycle of a read the freshly assembled line is shown
  // directly; it lands in rdata_q on the same edge that leaves RESP.
  assign pmem_rdata    = (state_q == PMEM_RESP && is_read_q) ? buf_line : rdata_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench for pmem_burst_responder. Expected lines and write
// beats are pushed onto scoreboard queues as stimulus is driven and popped
// when the DUT produces the matching output.
module tb_pmem_burst_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int total = 0;
  int bad   = 0;
  int cycleCount = 0;
  int lastRespCycle = 0;
  logic [255:0] lastReadLine = '0;
  logic [255:0] rdataQ[$];
  logic [63:0]  wdataQ[$];

  pmem_burst_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  // Free-running clock; inputs change and outputs are sampled on negedge.
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between completion pulses.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // The two burst directions must never be active together.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && burst_read === 1'b1 && burst_write === 1'b1) begin
      bad++;
      $display("[TB] FAIL exclusive_dir: burst_read=1 burst_write=1 required not both");
    end
  end

  // Run one line transfer. pat gives burst_resp per burst cycle (bit 0
  // first, ones after patLen); expLat is the cycle of pmem_resp counted
  // from the request cycle.
  task automatic do_xfer(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] line, input logic [15:0] pat,
                         input int patLen, input int expLat);
    logic [31:0]  expAddr;
    logic [255:0] expLine;
    logic [63:0]  expBeat;
    int mcnt = 0;
    int k = 0;
    int cyc = 0;
    bit done = 0;
    bit resp;
    @(negedge clk);
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_wdata   = wr ? line : ~line;
    expAddr      = addr & ~32'h1F;
    rdataQ.push_back(wr ? lastReadLine : line);
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      burst_resp = 1'b0;
      if (pmem_resp === 1'b1) begin
        lastRespCycle = cycleCount;
        total++;
        if (cyc !== expLat)
          begin bad++; $display("[TB] FAIL resp_latency: got=%0d want=%0d", cyc, expLat); end
        expLine = rdataQ.pop_front();
        total++;
        if (pmem_rdata !== expLine)
          begin bad++; $display("[TB] FAIL resp_rdata: got=%h want=%h", pmem_rdata, expLine); end
        if (!wr) lastReadLine = line;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        done = 1;
      end else begin
        total++;
        if (burst_address !== expAddr || burst_read !== !wr || burst_write !== wr)
          begin
            bad++;
            $display("[TB] FAIL burst_ctl: addr=%h rd=%b wr=%b want addr=%h rd=%b wr=%b",
                     burst_address, burst_read, burst_write, expAddr, !wr, wr);
          end
        if (wr && mcnt < 4) begin
          wdataQ.push_back(line[mcnt*64 +: 64]);
          expBeat = wdataQ.pop_front();
          total++;
          if (burst_wdata !== expBeat)
            begin bad++; $display("[TB] FAIL burst_wdata: got=%h want=%h beat=%0d", burst_wdata, expBeat, mcnt); end
        end
        resp = (k < patLen) ? pat[k] : 1'b1;
        k++;
        burst_resp  = resp && mcnt < 4;
        burst_rdata = (resp && mcnt < 4) ? line[mcnt*64 +: 64] : {$urandom, $urandom};
        if (resp && mcnt < 4) mcnt++;
      end
    end
    if (!done) begin
      bad++;
      $display("[TB] FAIL resp_timeout: got=no pmem_resp want=pmem_resp within 64 cycles");
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    @(negedge clk);
    total++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== lastReadLine)
      begin
        bad++;
        $display("[TB] FAIL after_resp: resp=%b rdata=%h want resp=0 rdata=%h", pmem_resp, pmem_rdata, lastReadLine);
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({pmem_resp, burst_read, burst_write} !== 3'b000 || burst_address !== '0 ||
        burst_wdata !== '0 || pmem_rdata !== '0)
      begin
        bad++;
        $display("[TB] FAIL reset_state: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
                 pmem_resp, burst_read, burst_write, burst_address, burst_wdata, pmem_rdata);
      end
    rst_n = 1'b1;
    lastReadLine = '0;
  endtask

  task automatic test_read_zero_wait();
    do_xfer(1'b0, 1'b1, 32'h0000_1234,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            16'hFFFF, 16, 5);
  endtask

  task automatic test_write_stalls();
    // Ack pattern 1,0,0,1,1,0,1 stretches the burst to seven cycles.
    do_xfer(1'b1, 1'b0, 32'h0000_8017,
            {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
             64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
            16'h0059, 7, 8);
  endtask

  task automatic test_read_write_both();
    do_xfer(1'b1, 1'b1, 32'hABCD_EF5F,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            16'hFFFF, 16, 5);
  endtask

  task automatic test_back_to_back();
    int firstResp;
    do_xfer(1'b1, 1'b0, 32'h0000_4000,
            {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
             64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000},
            16'hFFFF, 16, 5);
    firstResp = lastRespCycle;
    do_xfer(1'b0, 1'b1, 32'h0000_6020,
            {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
             64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000},
            16'h00F5, 6, 7);
    total++;
    if (lastRespCycle - firstResp < 6)
      begin bad++; $display("[TB] FAIL b2b_spacing: got=%0d want>=6", lastRespCycle - firstResp); end
  endtask

  task automatic test_reset_mid_read();
    int respSeen = 0;
    @(negedge clk);
    pmem_address = 32'h0000_2040;
    pmem_read    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    burst_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pmem_resp, burst_read, burst_write} !== 3'b000 || burst_address !== '0 ||
        burst_wdata !== '0 || pmem_rdata !== '0)
      begin
        bad++;
        $display("[TB] FAIL midreset_outputs: resp=%b rd=%b wr=%b addr=%h rdata=%h want all 0",
                 pmem_resp, burst_read, burst_write, burst_address, pmem_rdata);
      end
    pmem_read = 1'b0;
    rdataQ.delete();
    lastReadLine = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) respSeen++;
    end
    total++;
    if (respSeen != 0)
      begin bad++; $display("[TB] FAIL midreset_noresp: got=%0d pulses want=0", respSeen); end
    do_xfer(1'b0, 1'b1, 32'h0000_2040,
            {64'hFEED_0000_0000_0003, 64'hFEED_0000_0000_0002,
             64'hFEED_0000_0000_0001, 64'hFEED_0000_0000_0000},
            16'hFFFF, 16, 5);
  endtask

  task automatic test_idle_stability();
    int badCycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (burst_read !== 1'b0 || burst_write !== 1'b0 || pmem_resp !== 1'b0 ||
          pmem_rdata !== lastReadLine)
        badCycles++;
    end
    total++;
    if (badCycles != 0)
      begin bad++; $display("[TB] FAIL idle_stable: got=%0d disturbed cycles want=0", badCycles); end
  endtask

  // Scenario sequence; each task does its own comparisons.
  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_stalls();
    test_read_write_both();
    test_back_to_back();
    test_reset_mid_read();
    test_idle_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
